// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph table (g..a, active-low) and hex decode helper.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t GLYPH_0   = 7'b1000000;
  localparam seg_t GLYPH_1   = 7'b1111001;
  localparam seg_t GLYPH_2   = 7'b0100100;
  localparam seg_t GLYPH_3   = 7'b0110000;
  localparam seg_t GLYPH_4   = 7'b0011001;
  localparam seg_t GLYPH_5   = 7'b0010010;
  localparam seg_t GLYPH_6   = 7'b0000010;
  localparam seg_t GLYPH_7   = 7'b1111000;
  localparam seg_t GLYPH_8   = 7'b0000000;
  localparam seg_t GLYPH_9   = 7'b0010000;
  localparam seg_t GLYPH_A   = 7'b0001000;
  localparam seg_t GLYPH_B   = 7'b0000011;
  localparam seg_t GLYPH_C   = 7'b1000110;
  localparam seg_t GLYPH_D   = 7'b0100001;
  localparam seg_t GLYPH_E   = 7'b0000110;
  localparam seg_t GLYPH_F   = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  function automatic seg_t hex_decode(input logic [3:0] nib, input logic blank);
    seg_t seg;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (nib)
        4'h0:    seg = GLYPH_0;
        4'h1:    seg = GLYPH_1;
        4'h2:    seg = GLYPH_2;
        4'h3:    seg = GLYPH_3;
        4'h4:    seg = GLYPH_4;
        4'h5:    seg = GLYPH_5;
        4'h6:    seg = GLYPH_6;
        4'h7:    seg = GLYPH_7;
        4'h8:    seg = GLYPH_8;
        4'h9:    seg = GLYPH_9;
        4'hA:    seg = GLYPH_A;
        4'hB:    seg = GLYPH_B;
        4'hC:    seg = GLYPH_C;
        4'hD:    seg = GLYPH_D;
        4'hE:    seg = GLYPH_E;
        default: seg = GLYPH_F;
      endcase
    end
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-glyph decoder; output is always the active-low pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output seg_t       o_seg
);

  assign o_seg = hex_decode(i_nibble, i_blank);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous content update,
// per-digit blanking and leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  output logic                    ready,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_suppress,
  output logic [6:0]              D_SEG,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_start
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam seg_t                  SEG_OFF = (ACTIVE_LOW != 0) ? SEG_BLANK : ~SEG_BLANK;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_val, r_act_val;
  logic [NUM_DIGITS-1:0]   r_pend_mask, r_act_mask;
  logic                    r_pend_lz, r_act_lz, r_pend_valid;
  seg_t                    r_seg;
  logic [NUM_DIGITS-1:0]   r_dig;
  logic                    r_fs;

  logic                    w_tick, w_last, w_bound, w_copy, w_accept;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] w_val_nxt;
  logic [NUM_DIGITS-1:0]   w_mask_nxt, w_lzb, w_onehot;
  logic                    w_lz_nxt, w_blank;
  logic [3:0]              w_nib;
  seg_t                    w_seg;

  assign w_tick    = (r_cnt == CNT_MAX);
  assign w_last    = (r_idx == IDX_MAX);
  assign w_bound   = w_tick && w_last;
  assign w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
  assign w_idx_nxt = !w_tick ? r_idx : (w_last ? '0 : r_idx + 3'd1);

  // A load accepted on the boundary tick only sets pending; it is copied at the next boundary.
  assign w_accept   = load && !r_pend_valid;
  assign w_copy     = w_bound && r_pend_valid;
  assign w_val_nxt  = w_copy ? r_pend_val  : r_act_val;
  assign w_mask_nxt = w_copy ? r_pend_mask : r_act_mask;
  assign w_lz_nxt   = w_copy ? r_pend_lz   : r_act_lz;

  // Outputs are decoded from next-state index/content so they land with the index update.
  always_comb begin
    logic run;
    w_lzb    = '0;
    w_onehot = '0;
    w_nib    = '0;
    w_blank  = 1'b0;
    run      = w_lz_nxt;
    for (int unsigned i = NUM_DIGITS - 1; i > 0; i--) begin
      run      = run && (w_val_nxt[4*i +: 4] == 4'h0);
      w_lzb[i] = run;
    end
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      w_onehot[i] = (w_idx_nxt == IDX_W'(i));
      if (w_onehot[i]) begin
        w_nib   = w_val_nxt[4*i +: 4];
        w_blank = w_mask_nxt[i] | w_lzb[i];
      end
    end
  end

  seg7_hex_decode u_dec (
    .i_nibble (w_nib),
    .i_blank  (w_blank),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_pend_val   <= '0;
      r_pend_mask  <= '0;
      r_pend_lz    <= 1'b0;
      r_pend_valid <= 1'b0;
      r_act_val    <= '0;
      r_act_mask   <= '1;
      r_act_lz     <= 1'b0;
      r_seg        <= SEG_OFF;
      r_dig        <= DIG_OFF;
      r_fs         <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_act_val  <= w_val_nxt;
      r_act_mask <= w_mask_nxt;
      r_act_lz   <= w_lz_nxt;
      if (w_accept) begin
        r_pend_val   <= value;
        r_pend_mask  <= blank_mask;
        r_pend_lz    <= lz_suppress;
        r_pend_valid <= 1'b1;
      end else if (w_copy) begin
        r_pend_valid <= 1'b0;
      end
      r_seg <= (ACTIVE_LOW != 0) ? w_seg : ~w_seg;
      r_dig <= (ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
      r_fs  <= w_bound;
    end
  end

  assign ready       = !r_pend_valid;
  assign D_SEG       = r_seg;
  assign dig_en      = r_dig;
  assign frame_start = r_fs;

endmodule
